// File: rtl/cv32e40p_pkg.sv
// Shared write-back types and constants for the EX/WB boundary.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cv32e40p_pkg;

  localparam int WB_ADDR_W  = 6;
  localparam int WB_DATA_W  = 32;
  localparam int WB_NUM_SRC = 3;

  // Result producers feeding the register-file write port
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_XIF = 2;

  // One buffered register-file write
  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_req_t;

  // Increment modulo n, used for wrapping indices
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// Single-source write-back FIFO exposing its whole entry array for hazard lookup.
// Latency: no fall-through, a pushed entry is visible at the head one cycle later.
// Backpressure: push ignored when full (even with a same-cycle pop); flush wins over push/pop.
module cv32e40p_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  logic [W-1:0]            push_dat,
  input  logic                    pop,
  output logic [W-1:0]            head_dat,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0][W-1:0] entries,
  output logic [DEPTH-1:0]        entry_vld
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rptr;
  logic [PW-1:0]           wptr;
  logic [CW-1:0]           cnt;
  logic                    do_push;
  logic                    do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign head_dat = mem[rptr];
  assign entries  = mem;

  // Pointer and occupancy bookkeeping; flush drops everything at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= ptr_inc(wptr);
      if (do_pop)  rptr <= ptr_inc(rptr);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (!do_push && do_pop) cnt <= cnt - CW'(1);
    end
  end

  // Payload storage needs no reset: validity comes from the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

  // An entry is live when its distance from the read pointer is below the occupancy
  always_comb begin
    int off;
    off       = 0;
    entry_vld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      off = (k >= int'(rptr)) ? k - int'(rptr) : k + DEPTH - int'(rptr);
      entry_vld[k] = (off < int'(cnt));
    end
  end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// Register-file write-port arbiter: per-source FIFOs, one grant per cycle, RAW lookup.
// Latency: one cycle from push to earliest write; the write port is combinational from FIFO heads.
// Backpressure: src_ready_o drops when a FIFO is full or during flush; rf_ready_i=0 holds all heads.
module cv32e40p_wb_arbiter import cv32e40p_pkg::*; #(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int DATA_W     = WB_DATA_W,
  parameter int RR_MODE    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_SRC-1:0]         src_valid_i,
  output logic [NUM_SRC-1:0]         src_ready_o,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_waddr_i,
  input  logic [NUM_SRC*DATA_W-1:0]  src_wdata_i,
  input  logic                       rf_ready_i,
  output logic                       wr_we_o,
  output logic [ADDR_W-1:0]          wr_waddr_o,
  output logic [DATA_W-1:0]          wr_wdata_o,
  output logic [$clog2(NUM_SRC)-1:0] wr_src_o,
  input  logic [ADDR_W-1:0]          lookup_addr_i,
  output logic                       lookup_hit_o,
  output logic                       busy_o
);

  localparam int SRC_W    = $clog2(NUM_SRC);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int REQ_W    = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t                             head     [NUM_SRC];
  logic [FIFO_DEPTH-1:0][REQ_W-1:0] ents     [NUM_SRC];
  logic [FIFO_DEPTH-1:0]            ents_vld [NUM_SRC];
  logic [NUM_SRC-1:0]               full;
  logic [NUM_SRC-1:0]               empty;
  logic [NUM_SRC-1:0]               gnt_oh;
  logic                             gnt_vld;
  logic [SRC_W-1:0]                 gnt_idx;
  logic [SRC_W-1:0]                 rr_ptr;
  logic [STARVE_W-1:0]              starve_cnt [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    req_t push_req;
    assign push_req.waddr = src_waddr_i[i*ADDR_W +: ADDR_W];
    assign push_req.wdata = src_wdata_i[i*DATA_W +: DATA_W];
    assign src_ready_o[i] = ~full[i] & ~flush_i;
    assign gnt_oh[i]      = gnt_vld & (gnt_idx == SRC_W'(i));

    cv32e40p_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (REQ_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .push      (src_valid_i[i]),
      .push_dat  (push_req),
      .pop       (gnt_oh[i]),
      .head_dat  (head[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .entries   (ents[i]),
      .entry_vld (ents_vld[i])
    );
  end

  assign busy_o = |(~empty);

  // Winner selection; scans run high-to-low so the last match is the preferred one
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rf_ready_i && !flush_i) begin
      if (RR_MODE != 0) begin
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
          idx = (int'(rr_ptr) + k) % NUM_SRC;
          if (!empty[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = SRC_W'(idx);
          end
        end
      end else begin
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (!empty[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SRC_W'(i);
          end
        end
        // A starved source overrides plain priority; lowest starved index wins
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
          if (!empty[i] && starve_cnt[i] == STARVE_W'(STARVE_MAX)) gnt_idx = SRC_W'(i);
        end
      end
    end
  end

  // Starvation counters and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) starve_cnt[i] <= '0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (flush_i || empty[i] || gnt_oh[i])
          starve_cnt[i] <= '0;
        else if (starve_cnt[i] != STARVE_W'(STARVE_MAX))
          starve_cnt[i] <= starve_cnt[i] + STARVE_W'(1);
      end
      if (gnt_vld) rr_ptr <= SRC_W'(wrap_inc(int'(gnt_idx), NUM_SRC));
    end
  end

  // Write-port mux; an x0 head still consumes its grant but never writes
  always_comb begin
    wr_we_o    = 1'b0;
    wr_waddr_o = '0;
    wr_wdata_o = '0;
    wr_src_o   = '0;
    if (gnt_vld) begin
      wr_we_o    = (head[gnt_idx].waddr != '0);
      wr_waddr_o = head[gnt_idx].waddr;
      wr_wdata_o = head[gnt_idx].wdata;
      wr_src_o   = gnt_idx;
    end
  end

  // RAW lookup over every live entry, including the one being popped now
  always_comb begin
    lookup_hit_o = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        if (ents_vld[i][k] && ents[i][k][REQ_W-1 -: ADDR_W] == lookup_addr_i) lookup_hit_o = 1'b1;
      end
    end
    if (lookup_addr_i == '0) lookup_hit_o = 1'b0;
  end

endmodule

// File: tb/tb_cv32e40p_wb_arbiter.sv
// Scoreboard bench for the write-back arbiter in fixed-priority and round-robin flavours.
// Latency: checks are taken 1 time unit after each falling edge, writes 2 units after.
// Backpressure: rf_ready_i and flush_i are driven directed first, then randomly.
module tb_cv32e40p_wb_arbiter;
  import cv32e40p_pkg::*;

  localparam int N = 3, D = 2, AW = 6, DW = 32, SM = 4, SW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush_i, rf_ready_i;
  logic [N-1:0]    src_valid_i;
  logic [N*AW-1:0] src_waddr_i;
  logic [N*DW-1:0] src_wdata_i;
  logic [AW-1:0]   lookup_addr_i;

  logic [N-1:0]  rdy  [2];
  logic          we   [2];
  logic [AW-1:0] wa   [2];
  logic [DW-1:0] wd   [2];
  logic [SW-1:0] ws   [2];
  logic          hit  [2];
  logic          busy [2];

  always #5 clk = ~clk;

  cv32e40p_wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .STARVE_MAX(SM)) dut_fx (
    .clk(clk), .rst(rst), .flush_i(flush_i), .src_valid_i(src_valid_i), .src_ready_o(rdy[0]),
    .src_waddr_i(src_waddr_i), .src_wdata_i(src_wdata_i), .rf_ready_i(rf_ready_i),
    .wr_we_o(we[0]), .wr_waddr_o(wa[0]), .wr_wdata_o(wd[0]), .wr_src_o(ws[0]),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(hit[0]), .busy_o(busy[0]));

  cv32e40p_wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .STARVE_MAX(SM)) dut_rr (
    .clk(clk), .rst(rst), .flush_i(flush_i), .src_valid_i(src_valid_i), .src_ready_o(rdy[1]),
    .src_waddr_i(src_waddr_i), .src_wdata_i(src_wdata_i), .rf_ready_i(rf_ready_i),
    .wr_we_o(we[1]), .wr_waddr_o(wa[1]), .wr_wdata_o(wd[1]), .wr_src_o(ws[1]),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(hit[1]), .busy_o(busy[1]));

  // Reference state: one queue of {addr,data} per source, per arbiter flavour
  logic [AW+DW-1:0] mq [2][N][$];
  int               scnt [2][N];
  int               rrp [2];
  logic [55:0]      eq [2][$];   // expected writes {cycle[15:0], src, addr, data}
  int               glog [2][$]; // observed written source per cycle, -1 when none
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N*AW-1:0] pa(input int a0, input int a1, input int a2);
    return {AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [N*DW-1:0] pd(input int d0, input int d1, input int d2);
    return {DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        mq[m][i].delete();
        scnt[m][i] = 0;
      end
      rrp[m] = 0;
    end
  endtask

  // Evaluate one cycle of the reference for flavour m against the current inputs
  task automatic model_step(input int m);
    bit [N-1:0] el, er;
    bit         any_hit;
    int         g;
    el = '0; er = '0; any_hit = 1'b0; g = -1;
    for (int i = 0; i < N; i++) begin
      el[i] = (mq[m][i].size() != 0);
      er[i] = (mq[m][i].size() < D) && !flush_i;
      for (int k = 0; k < mq[m][i].size(); k++)
        if (mq[m][i][k][AW+DW-1:DW] == lookup_addr_i && lookup_addr_i != 0) any_hit = 1'b1;
    end
    if (rf_ready_i && !flush_i && el != 0) begin
      if (m == 1) begin
        for (int k = 0; k < N; k++) if (g < 0 && el[(rrp[m] + k) % N]) g = (rrp[m] + k) % N;
      end else begin
        for (int i = 0; i < N; i++) if (g < 0 && el[i] && scnt[m][i] == SM) g = i;
        for (int i = 0; i < N; i++) if (g < 0 && el[i]) g = i;
      end
    end
    chk($sformatf("src_ready dut%0d", m), 64'(rdy[m]), 64'(er));
    chk($sformatf("busy dut%0d", m), 64'(busy[m]), 64'(|el));
    chk($sformatf("lookup_hit dut%0d", m), 64'(hit[m]), 64'(any_hit));
    if (g < 0) chk($sformatf("idle_port dut%0d", m), {we[m], ws[m], wa[m], wd[m]}, 64'd0);
    else if (mq[m][g][0][AW+DW-1:DW] == 0) chk($sformatf("x0_no_we dut%0d", m), 64'(we[m]), 64'd0);
    else eq[m].push_back({cyc[15:0], 2'(g), mq[m][g][0]});
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        mq[m][i].delete();
        scnt[m][i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i == g || !el[i]) scnt[m][i] = 0;
        else if (scnt[m][i] < SM) scnt[m][i]++;
      end
      if (g >= 0) begin
        void'(mq[m][g].pop_front());
        rrp[m] = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (src_valid_i[i] && er[i]) mq[m][i].push_back({src_waddr_i[i*AW +: AW], src_wdata_i[i*DW +: DW]});
    end
  endtask

  task automatic cycle(input bit [N-1:0] v, input bit [N*AW-1:0] a, input bit [N*DW-1:0] d,
                       input bit rr, input bit fl, input bit [AW-1:0] lk);
    @(negedge clk);
    cyc++;
    src_valid_i = v; src_waddr_i = a; src_wdata_i = d;
    rf_ready_i = rr; flush_i = fl; lookup_addr_i = lk;
    #1;
    model_step(0);
    model_step(1);
    for (int m = 0; m < 2; m++) glog[m].push_back(we[m] ? int'(ws[m]) : -1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s port dut%0d", tag, m), {we[m], ws[m], wa[m], wd[m]}, 64'd0);
      chk($sformatf("%s hit_busy dut%0d", tag, m), {hit[m], busy[m]}, 64'd0);
      chk($sformatf("%s ready dut%0d", tag, m), 64'(rdy[m]), 64'h7);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard head
  initial begin
    logic [55:0] e;
    forever begin
      @(negedge clk);
      #2;
      for (int m = 0; m < 2; m++) begin
        if (!rst && we[m]) begin
          if (eq[m].size() == 0) begin
            total++; bad++;
            $display("FAIL write dut%0d: got src=%0d addr=%0d data=0x%0h, required no write (cycle %0d)",
                     m, ws[m], wa[m], wd[m], cyc);
          end else begin
            e = eq[m].pop_front();
            chk($sformatf("write dut%0d", m), {8'd0, cyc[15:0], ws[m], wa[m], wd[m]}, {8'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_fx [7];
    int exp_rr [7];
    exp_fx = '{-1, 0, 0, 0, 0, 2, 0};
    exp_rr = '{-1, 0, 1, 2, 0, 1, 2};
    rst = 1'b1; flush_i = 1'b0; rf_ready_i = 1'b0; src_valid_i = '0;
    src_waddr_i = '0; src_wdata_i = '0; lookup_addr_i = '0;
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single push from the LSU source
    cycle(3'b010, pa(0, 5, 0), pd(0, 32'hDEADBEEF, 0), 1'b1, 1'b0, '0);
    cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    chk("single_push", {we[0], ws[0], wa[0], wd[0]}, {1'b1, 2'(WB_SRC_LSU), 6'd5, 32'hDEADBEEF});
    cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    chk("single_push_idle_busy", 64'(busy[0]), 64'd0);

    // Fixed priority with starvation guard: src0 and src2 push every cycle
    glog[0].delete();
    for (int c = 0; c < 7; c++) cycle(3'b101, pa(1, 0, 3), pd(c, 0, 100 + c), 1'b1, 1'b0, 6'd1);
    for (int c = 0; c < 7; c++) chk($sformatf("starve_seq[%0d]", c), 64'(glog[0][c]), 64'(exp_fx[c]));

    // Reset in the middle of a drain
    cycle(3'b000, '0, '0, 1'b1, 1'b0, 6'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    model_reset();
    src_valid_i = '0;
    @(negedge clk);
    rst = 1'b0;

    // Round-robin with all sources kept non-empty
    glog[1].delete();
    for (int c = 0; c < 7; c++) cycle(3'b111, pa(2, 4, 6), pd(c, 10 + c, 20 + c), 1'b1, 1'b0, '0);
    for (int c = 0; c < 7; c++) chk($sformatf("rr_seq[%0d]", c), 64'(glog[1][c]), 64'(exp_rr[c]));
    for (int c = 0; c < 8; c++) cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);

    // Backpressure: third push into a depth-2 FIFO is refused
    cycle(3'b001, pa(10, 0, 0), pd(32'hA1, 0, 0), 1'b0, 1'b0, '0);
    cycle(3'b001, pa(11, 0, 0), pd(32'hA2, 0, 0), 1'b0, 1'b0, '0);
    cycle(3'b001, pa(12, 0, 0), pd(32'hA3, 0, 0), 1'b0, 1'b0, '0);
    chk("full_ready_low", 64'(rdy[0][0]), 64'd0);
    cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    chk("drain_first", {we[0], wa[0], wd[0]}, {1'b1, 6'd10, 32'hA1});
    cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    chk("drain_second", {we[0], wa[0], wd[0]}, {1'b1, 6'd11, 32'hA2});
    cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    chk("drain_done_busy", 64'(busy[0]), 64'd0);

    // x0 write and lookup
    cycle(3'b100, pa(0, 0, 0), pd(0, 0, 32'h11), 1'b0, 1'b0, 6'd7);
    cycle(3'b100, pa(0, 0, 7), pd(0, 0, 32'h22), 1'b0, 1'b0, 6'd0);
    chk("lookup_x0_never", 64'(hit[0]), 64'd0);
    cycle(3'b000, '0, '0, 1'b0, 1'b0, 6'd7);
    chk("lookup_x7_pending", 64'(hit[0]), 64'd1);
    cycle(3'b000, '0, '0, 1'b1, 1'b0, 6'd7);
    chk("x0_grant", {we[0], hit[0]}, {1'b0, 1'b1});
    cycle(3'b000, '0, '0, 1'b1, 1'b0, 6'd7);
    chk("x7_write", {we[0], wa[0], wd[0], hit[0]}, {1'b1, 6'd7, 32'h22, 1'b1});
    cycle(3'b000, '0, '0, 1'b1, 1'b0, 6'd7);
    chk("x7_popped_hit", 64'(hit[0]), 64'd0);

    // Flush with a simultaneous push while two entries are buffered
    cycle(3'b001, pa(20, 0, 0), pd(1, 0, 0), 1'b0, 1'b0, '0);
    cycle(3'b001, pa(21, 0, 0), pd(2, 0, 0), 1'b0, 1'b0, '0);
    cycle(3'b010, pa(0, 22, 0), pd(0, 3, 0), 1'b1, 1'b1, '0);
    chk("flush_cycle", {we[0], rdy[0]}, 64'd0);
    cycle(3'b000, '0, '0, 1'b1, 1'b0, 6'd22);
    chk("after_flush", {we[0], busy[0], hit[0]}, 64'd0);

    // Randomised traffic against the reference
    for (int c = 0; c < 2000; c++)
      cycle(3'($urandom_range(0, 7)),
            pa($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            pd($urandom, $urandom, $urandom),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 6'($urandom_range(0, 7)));
    for (int c = 0; c < 8; c++) cycle(3'b000, '0, '0, 1'b1, 1'b0, '0);
    @(negedge clk);
    #3;
    for (int m = 0; m < 2; m++) chk($sformatf("writes_outstanding dut%0d", m), 64'(eq[m].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
